// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: D = A - B mod 2^N, one bit per clock, LSB first.
// A single full-subtractor cell feeds a borrow flop; start/busy/done handshake around it.
module serial_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  ra_reg, rb_reg, rr_reg;
  logic          br_reg;
  logic [CW-1:0] count_reg;

  logic          a0, b0, d_bit, br_next, last_bit;
  logic [N-1:0]  rr_next;

  // Full-subtractor cell on the current LSBs
  assign a0       = ra_reg[0];
  assign b0       = rb_reg[0];
  assign d_bit    = a0 ^ b0 ^ br_reg;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
  assign rr_next  = {d_bit, rr_reg[N-1:1]};
  assign last_bit = (count_reg == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_reg    <= '0;
      rb_reg    <= '0;
      rr_reg    <= '0;
      br_reg    <= 1'b0;
      count_reg <= '0;
      D         <= '0;
      Bout      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            ra_reg    <= A;
            rb_reg    <= B;
            rr_reg    <= '0;
            br_reg    <= 1'b0;
            count_reg <= '0;
          end
        end
        SHIFT: begin
          ra_reg <= ra_reg >> 1;
          rb_reg <= rb_reg >> 1;
          rr_reg <= rr_next;
          br_reg <= br_next;
          // Results are published only on the final bit so D/Bout stay stable while busy
          if (last_bit) begin
            D    <= rr_next;
            Bout <= br_next;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: randomized operands against an arithmetic model
// of unsigned subtraction, plus handshake timing, busy-start, back-to-back and reset-abort.
module tb_serial_sub;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy, done, Bout;
  logic [N-1:0] D;

  int checks = 0;
  int errors = 0;

  int           obs_lat, obs_busy_cnt;
  bit           obs_d_changed;
  logic [N-1:0] obs_d;
  logic         obs_bout, obs_after_busy, obs_after_done;

  serial_sub #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .D    (D),
    .Bout (Bout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Stimulus driver: one accepted operation, records observations for the caller to judge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] d_before;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    d_before = D;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = N'($urandom); B = N'($urandom);
    obs_busy_cnt  = busy ? 1 : 0;
    obs_d_changed = 1'b0;
    obs_lat       = -1;
    for (int i = 1; i <= N + 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) obs_busy_cnt++;
      if (done) begin
        obs_lat = i;
        break;
      end
      if (D !== d_before) obs_d_changed = 1'b1;
    end
    obs_d    = D;
    obs_bout = Bout;
    @(posedge clk);
    @(negedge clk);
    obs_after_busy = busy;
    obs_after_done = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, D, Bout} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b D=%h Bout=%b want all 0", busy, done, D, Bout);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, D, Bout} !== '0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got busy=%b done=%b D=%h Bout=%b want all 0",
                 i, busy, done, D, Bout);
      end
    end
    $display("test_reset: outputs zero and stable for 20 idle cycles");
  endtask

  task automatic test_basic();
    run_op(8'd5, 8'd3);
    $display("op A=05 B=03 -> D=%h Bout=%b lat=%0d busy_cycles=%0d", obs_d, obs_bout, obs_lat, obs_busy_cnt);
    checks++;
    if (obs_lat !== N) begin
      errors++; $display("FAIL basic_latency got %0d want %0d", obs_lat, N);
    end
    checks++;
    if (obs_d !== 8'd2 || obs_bout !== 1'b0) begin
      errors++; $display("FAIL basic_result got D=%h Bout=%b want D=02 Bout=0", obs_d, obs_bout);
    end
    checks++;
    if (obs_busy_cnt !== N + 1) begin
      errors++; $display("FAIL basic_busy_cycles got %0d want %0d", obs_busy_cnt, N + 1);
    end
    checks++;
    if (obs_d_changed !== 1'b0) begin
      errors++; $display("FAIL basic_d_early got changed=%b want 0", obs_d_changed);
    end
    checks++;
    if (obs_after_busy !== 1'b0 || obs_after_done !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle got busy=%b done=%b want 0 0", obs_after_busy, obs_after_done);
    end
    checks++;
    if (D !== 8'd2 || Bout !== 1'b0) begin
      errors++; $display("FAIL basic_hold got D=%h Bout=%b want D=02 Bout=0", D, Bout);
    end
  endtask

  task automatic test_borrow();
    run_op(8'd3, 8'd5);
    $display("op A=03 B=05 -> D=%h Bout=%b lat=%0d", obs_d, obs_bout, obs_lat);
    checks++;
    if (obs_d !== 8'hFE || obs_bout !== 1'b1 || obs_lat !== N) begin
      errors++;
      $display("FAIL borrow got D=%h Bout=%b lat=%0d want D=fe Bout=1 lat=%0d", obs_d, obs_bout, obs_lat, N);
    end
  endtask

  task automatic test_boundary();
    logic [N-1:0] ta [4] = '{8'h00, 8'hFF, 8'h00, 8'hAA};
    logic [N-1:0] tb [4] = '{8'h00, 8'h01, 8'hFF, 8'hAA};
    logic [N-1:0] exp_d;
    logic         exp_b;
    for (int i = 0; i < 4; i++) begin
      exp_d = ta[i] - tb[i];
      exp_b = (ta[i] < tb[i]);
      run_op(ta[i], tb[i]);
      $display("op A=%h B=%h -> D=%h Bout=%b (want %h %b)", ta[i], tb[i], obs_d, obs_bout, exp_d, exp_b);
      checks++;
      if (obs_d !== exp_d || obs_bout !== exp_b || obs_lat !== N) begin
        errors++;
        $display("FAIL boundary_%0d got D=%h Bout=%b lat=%0d want D=%h Bout=%b lat=%0d",
                 i, obs_d, obs_bout, obs_lat, exp_d, exp_b, N);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, exp_d;
    logic         exp_b;
    for (int i = 0; i < 30; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      exp_d = a - b;
      exp_b = (a < b);
      run_op(a, b);
      $display("op A=%h B=%h -> D=%h Bout=%b (want %h %b)", a, b, obs_d, obs_bout, exp_d, exp_b);
      checks++;
      if (obs_d !== exp_d || obs_bout !== exp_b || obs_lat !== N) begin
        errors++;
        $display("FAIL random_%0d A=%h B=%h got D=%h Bout=%b lat=%0d want D=%h Bout=%b lat=%0d",
                 i, a, b, obs_d, obs_bout, obs_lat, exp_d, exp_b, N);
      end
    end
  endtask

  task automatic test_start_during_busy();
    int           done_cnt = 0;
    int           first_i = -1;
    logic [N-1:0] got_d = '0;
    logic         got_b = 1'b0;
    @(negedge clk);
    A = 8'd9; B = 8'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 2 * N + 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_i = i; got_d = D; got_b = Bout;
        end
      end
      if (i == 3) begin A = 8'd1; B = 8'd2; start = 1'b1; end
      if (i == 4) start = 1'b0;
    end
    $display("op A=09 B=04 with start while busy -> dones=%0d D=%h Bout=%b at %0d", done_cnt, got_d, got_b, first_i);
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL busy_start_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (got_d !== 8'd5 || got_b !== 1'b0 || first_i !== N) begin
      errors++;
      $display("FAIL busy_start_result got D=%h Bout=%b at %0d want D=05 Bout=0 at %0d", got_d, got_b, first_i, N);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2;
    int           pos [$];
    logic [N-1:0] dq [$];
    logic         bq [$];
    a1 = N'($urandom); b1 = N'($urandom);
    a2 = N'($urandom); b2 = N'($urandom);
    @(negedge clk);
    A = a1; B = b1; start = 1'b1;
    @(posedge clk);
    #1;
    A = a2; B = b2;
    for (int i = 1; i <= 2 * N + 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pos.push_back(i); dq.push_back(D); bq.push_back(Bout);
        if (pos.size() == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
    $display("back_to_back A1=%h B1=%h A2=%h B2=%h dones=%0d", a1, b1, a2, b2, pos.size());
    checks++;
    if (pos.size() !== 2) begin
      errors++; $display("FAIL b2b_done_count got %0d want 2", pos.size());
    end else begin
      checks++;
      if (pos[0] !== N || pos[1] !== 2 * N + 2) begin
        errors++; $display("FAIL b2b_timing got %0d,%0d want %0d,%0d", pos[0], pos[1], N, 2 * N + 2);
      end
      checks++;
      if (dq[0] !== N'(a1 - b1) || bq[0] !== (a1 < b1)) begin
        errors++; $display("FAIL b2b_first got D=%h Bout=%b want D=%h Bout=%b", dq[0], bq[0], N'(a1 - b1), (a1 < b1));
      end
      checks++;
      if (dq[1] !== N'(a2 - b2) || bq[1] !== (a2 < b2)) begin
        errors++; $display("FAIL b2b_second got D=%h Bout=%b want D=%h Bout=%b", dq[1], bq[1], N'(a2 - b2), (a2 < b2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int saw_done = 0;
    int saw_busy = 0;
    run_op(8'h80, 8'h01);
    checks++;
    if (obs_d !== 8'h7F || obs_bout !== 1'b0) begin
      errors++; $display("FAIL pre_reset_result got D=%h Bout=%b want D=7f Bout=0", obs_d, obs_bout);
    end
    @(negedge clk);
    A = 8'h3C; B = 8'hC3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    $display("reset mid-op -> busy=%b done=%b D=%h Bout=%b", busy, done, D, Bout);
    checks++;
    if ({busy, done, D, Bout} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b D=%h Bout=%b want all 0", busy, done, D, Bout);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (done) saw_done++;
      if (busy) saw_busy++;
    end
    checks++;
    if (saw_done !== 0 || saw_busy !== 0) begin
      errors++; $display("FAIL aborted_op got dones=%0d busy_cycles=%0d want 0 0", saw_done, saw_busy);
    end
    run_op(8'd7, 8'd7);
    $display("op A=07 B=07 after reset -> D=%h Bout=%b lat=%0d", obs_d, obs_bout, obs_lat);
    checks++;
    if (obs_d !== 8'd0 || obs_bout !== 1'b0 || obs_lat !== N) begin
      errors++;
      $display("FAIL post_reset_op got D=%h Bout=%b lat=%0d want D=00 Bout=0 lat=%0d", obs_d, obs_bout, obs_lat, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_boundary();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
